// File: rtl/i2c_fclk.sv
// i2c_fclk: free-running SCL bit-clock generator.
// Divides clk by DIV to make an idle-high s_clk and emits one-cycle strobes
// aligned with the s_clk rising (strob_up) and falling (strob_down) edges.
// DIV must be an integer >= 4 so that HALF-1 and DIV-1 are distinct counts.
module i2c_fclk #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCL_FREQ = 100_000,
  parameter int DIV      = CLK_FREQ / SCL_FREQ,
  parameter int HALF     = DIV / 2
) (
  input  logic clk,
  input  logic rst,
  output logic s_clk,
  output logic strob_up,
  output logic strob_down
);

  localparam int CW = $clog2(DIV);

  // Count values at which the next edge changes s_clk.
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FALL = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          s_clk_q;
  logic          s_clk_d;
  logic          up_q;
  logic          up_d;
  logic          down_q;
  logic          down_d;

  // Next-state decode: wrap the counter and schedule s_clk edges plus strobes.
  always_comb begin
    cnt_d   = cnt_q;
    s_clk_d = s_clk_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = {CW{1'b0}};
      s_clk_d = 1'b1;
      up_d    = 1'b1;
    end else if (cnt_q == CNT_FALL) begin
      cnt_d   = cnt_q + CNT_ONE;
      s_clk_d = 1'b0;
      down_d  = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_ONE;
    end
  end

  // State register; reset forces idle-high SCL and quiet strobes at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= {CW{1'b0}};
      s_clk_q <= 1'b1;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      s_clk_q <= s_clk_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign s_clk      = s_clk_q;
  assign strob_up   = up_q;
  assign strob_down = down_q;

endmodule

// File: tb/tb_i2c_fclk.sv
// tb_i2c_fclk: directed checks of i2c_fclk at 100 kHz (DIV=500) and
// 400 kHz (DIV=125) from a 50 MHz clk, with table-driven spot vectors.
module tb_i2c_fclk;

  logic clk;
  logic rst;
  logic s_clk;
  logic strob_up;
  logic strob_down;
  logic f_s_clk;
  logic f_strob_up;
  logic f_strob_down;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // posedges since last reset release
  int n_up   = 0;
  int n_down = 0;
  bit counting = 1'b0;

  i2c_fclk u_dut (
    .clk        (clk),
    .rst        (rst),
    .s_clk      (s_clk),
    .strob_up   (strob_up),
    .strob_down (strob_down)
  );

  i2c_fclk #(.SCL_FREQ(400_000)) u_fast (
    .clk        (clk),
    .rst        (rst),
    .s_clk      (f_s_clk),
    .strob_up   (f_strob_up),
    .strob_down (f_strob_down)
  );

  // 50 MHz clock, first posedge at 20 ns.
  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  typedef struct {
    int   k;
    logic s;
    logic u;
    logic d;
    logic fs;
    logic fu;
    logic fd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d t=%0t: got %b expected %b", name, k, $time, act, exp);
    end
  endtask

  // Independent waveform model: phase m = k mod div.
  task automatic model(input int kk, input int div, input int half,
                       output logic s, output logic u, output logic d);
    int m;
    m = kk % div;
    s = (m < half);
    d = (m == half);
    u = (m == 0) && (kk > 0);
  endtask

  // Advance one clk edge and compare both instances against the model.
  task automatic tick();
    logic s, u, d;
    @(posedge clk);
    k++;
    #2;
    model(k, 500, 250, s, u, d);
    chk("slow_scl",  s_clk,      s);
    chk("slow_up",   strob_up,   u);
    chk("slow_down", strob_down, d);
    chk("slow_excl", strob_up & strob_down, 1'b0);
    model(k, 125, 62, s, u, d);
    chk("fast_scl",  f_s_clk,      s);
    chk("fast_up",   f_strob_up,   u);
    chk("fast_down", f_strob_down, d);
    if (counting) begin
      if (strob_up)   n_up++;
      if (strob_down) n_down++;
    end
  endtask

  initial begin
    vecs[0]  = '{1,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{61,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{62,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{63,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{124,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{125,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{249,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{250,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{251,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{499,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{500,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{501,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{750,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset: assert at 5 ns, check reset values, release at 17 ns.
    rst = 1'b1;
    #5 rst = 1'b0;
    #1;
    chk("rst_scl",  s_clk,      1'b1);
    chk("rst_up",   strob_up,   1'b0);
    chk("rst_down", strob_down, 1'b0);
    chk("rst_fscl", f_s_clk,    1'b1);
    #11 rst = 1'b1;
    k = 0;
    counting = 1'b1;

    // Table-driven spot vectors, per-edge model checks in between.
    foreach (vecs[i]) begin
      while (k < vecs[i].k) tick();
      chk("vec_scl",   s_clk,        vecs[i].s);
      chk("vec_up",    strob_up,     vecs[i].u);
      chk("vec_down",  strob_down,   vecs[i].d);
      chk("vec_fscl",  f_s_clk,      vecs[i].fs);
      chk("vec_fup",   f_strob_up,   vecs[i].fu);
      chk("vec_fdown", f_strob_down, vecs[i].fd);
    end
    counting = 1'b0;

    // 100 us window: 10 falling strobes, 9 rising strobes.
    checks++;
    if (n_down != 10) begin
      errors++;
      $display("FAIL down_count: got %0d expected 10", n_down);
    end
    checks++;
    if (n_up != 9) begin
      errors++;
      $display("FAIL up_count: got %0d expected 9", n_up);
    end

    // Async reset in the middle of a low phase (cnt=300), between edges.
    while (k < 5300) tick();
    chk("pre_low_scl", s_clk, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_scl",  s_clk,      1'b1);
    chk("arst_up",   strob_up,   1'b0);
    chk("arst_down", strob_down, 1'b0);
    chk("arst_fscl", f_s_clk,    1'b1);
    @(posedge clk);
    #2;
    chk("held_scl",  s_clk,      1'b1);
    chk("held_down", strob_down, 1'b0);
    #5 rst = 1'b1;
    k = 0;

    // Restart from cnt=0: next fall exactly 250 edges after release.
    while (k < 252) tick();
    chk("restart_scl", s_clk, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
